// File: rtl/button_event_if.sv
// Event bundle between a debounced button level and the game logic.
// release/repeat are SV keywords, so those pulses carry a _p suffix.
interface button_event_if;
    logic debounceButton;
    logic press;
    logic release_p;
    logic repeat_p;
    logic held;
    logic dbl;

    modport master (
        output debounceButton,
        input  press, release_p, repeat_p, held, dbl
    );

    modport slave (
        input  debounceButton,
        output press, release_p, repeat_p, held, dbl
    );
endinterface

// File: rtl/button_event.sv
// Resynchronises a debounced button level and emits press/release/auto-repeat pulses.
// Optional double-tap detection is enabled by defining BUTTON_EVENT_DBL_EN.
module button_event #(
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned DBL_WINDOW    = 25000000,
    parameter int unsigned CNT_W         = 32
) (
    input logic           clk,
    input logic           rst,
    button_event_if.slave bif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam longint unsigned MAX_CNT_A = (64'(REPEAT_DELAY) > 64'(REPEAT_PERIOD)) ?
                                            64'(REPEAT_DELAY) : 64'(REPEAT_PERIOD);
    localparam longint unsigned MAX_CNT   = (MAX_CNT_A > 64'(DBL_WINDOW)) ?
                                            MAX_CNT_A : 64'(DBL_WINDOW);
    localparam longint unsigned CNT_MAX   = (64'd1 << CNT_W) - 64'd1;

    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || MAX_CNT > CNT_MAX) begin : g_bad_cfg
        $error("button_event: invalid REPEAT_DELAY/REPEAT_PERIOD/DBL_WINDOW/CNT_W");
    end

    localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] TMR_ONES  = '1;
`ifdef BUTTON_EVENT_DBL_EN
    localparam logic [CNT_W-1:0] DBL_LIM   = CNT_W'(DBL_WINDOW);
    // Saturated timer means "no release seen since reset", so no double tap.
    localparam logic [CNT_W-1:0] TMR_RST   = TMR_ONES;
`else
    localparam logic [CNT_W-1:0] TMR_RST   = '0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             press_q, press_d, rel_q, rel_d, rpt_q, rpt_d;
    logic             held_q, held_d, dbl_q, dbl_d;
    logic             rise, fall;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_comb begin
        s1_d    = bif.debounceButton;
        s2_d    = s1_q;
        s3_d    = s2_q;
        held_d  = s2_q;
        state_d = state_q;
        timer_d = timer_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rpt_d   = 1'b0;
        dbl_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_HOLD;
`ifdef BUTTON_EVENT_DBL_EN
                    dbl_d   = (timer_q < DBL_LIM);
`endif
                end
`ifdef BUTTON_EVENT_DBL_EN
                else if (timer_q != TMR_ONES) begin
                    timer_d = timer_q + CNT_W'(1);
                end
`endif
            end
            ST_HOLD: begin
                // Release has priority over a coincident terminal count.
                if (fall) begin
                    rel_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer_q == DELAY_TC) begin
                    rpt_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_REPEAT;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    rel_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer_q == PERIOD_TC) begin
                    rpt_d   = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = TMR_RST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= TMR_RST;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rpt_q   <= 1'b0;
            held_q  <= 1'b0;
            dbl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rpt_q   <= rpt_d;
            held_q  <= held_d;
            dbl_q   <= dbl_d;
        end
    end

    assign bif.press     = press_q;
    assign bif.release_p = rel_q;
    assign bif.repeat_p  = rpt_q;
    assign bif.held      = held_q;
    assign bif.dbl       = dbl_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: behavioural event model checked every cycle
// plus literal expectations taken from hand-computed timelines.
module tb_button_event;

    localparam int D  = 10;
    localparam int P  = 4;
    localparam int W  = 8;
    localparam int N  = 220;
`ifdef BUTTON_EVENT_DBL_EN
    localparam logic DBL_ON = 1'b1;
`else
    localparam logic DBL_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    button_event_if bif ();

    button_event #(
        .REPEAT_DELAY (D),
        .REPEAT_PERIOD(P),
        .DBL_WINDOW   (W),
        .CNT_W        (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bif(bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic x_tab [N];
    logic r_tab [N];

    int checks   = 0;
    int failures = 0;

    // Literal expectations: cycle, signal (0 press,1 release,2 repeat,3 held,4 dbl), value.
    localparam int NL = 30;
    int   lit_c [NL] = '{1,   7,   8,  8, 18, 22, 34, 38, 38, 48,
                         52, 53, 53, 73, 77, 77,111,112,113,116,
                        117,148,149,170,184,184,194,205,205, 34};
    int   lit_s [NL] = '{3,   3,   0,  3,  2,  2,  2,  1,  2,  0,
                          3,  1,  3,  2,  1,  2,  2,  3,  3,  0,
                          0,  0,  1,  4,  0,  4,  4,  4,  0,  1};
    logic lit_v [NL] = '{0,   0,   1,  1,  1,  1,  1,  1,  0,  1,
                          1,  1,  0,  1,  1,  0,  1,  0,  0,  0,
                          1,  1,  1, DBL_ON, 1, 0, DBL_ON, 0, 1, 0};

    function automatic logic xv(int i);
        return (i < 0) ? 1'b0 : x_tab[i];
    endfunction

    function automatic logic rv(int i);
        return (i < 0) ? 1'b1 : r_tab[i];
    endfunction

    function automatic logic anyr(int lo, int hi);
        logic a = 1'b0;
        for (int i = lo; i <= hi; i++) a = a | rv(i);
        return a;
    endfunction

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, k, act, exp);
        end
    endtask

    task automatic set_hi(input int a, input int b);
        for (int i = a; i <= b; i++) x_tab[i] = 1'b1;
    endtask

    // Stimulus table and driver: values for cycle c are applied just after posedge c.
    initial begin
        for (int i = 0; i < N; i++) begin
            x_tab[i] = 1'b0;
            r_tab[i] = 1'b0;
        end
        r_tab[0] = 1'b1; r_tab[1] = 1'b1; r_tab[2] = 1'b1;
        set_hi(5, 34);               // long hold, fall meets 6th repeat
        set_hi(45, 49);              // short press
        set_hi(60, 73);              // fall meets 2nd repeat terminal count
        set_hi(90, 130);             // reset while repeating
        r_tab[112] = 1'b1; r_tab[113] = 1'b1;
        x_tab[145] = 1'b1;           // 1-cycle pulse
        set_hi(160, 161);            // double-tap spacing sweep
        set_hi(167, 168);
        set_hi(181, 182);
        set_hi(191, 191);
        set_hi(202, 202);

        rst = 1'b1;
        bif.debounceButton = 1'b0;
        for (int c = 0; c < N; c++) begin
            @(posedge clk);
            #1;
            rst = r_tab[c];
            bif.debounceButton = x_tab[c];
        end
    end

    // Model: outputs at cycle k follow the input level seen three cycles earlier.
    initial begin
        int   p;
        int   last_rel;
        logic rel_valid;
        logic lvl, pv, rk, e_press, e_rel, e_rpt, e_dbl;
        logic act;
        p = -1000;
        last_rel = -1000;
        rel_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            lvl = xv(k - 3) & ~anyr(k - 3, k);
            pv  = xv(k - 4) & ~anyr(k - 4, k - 1);
            rk  = rv(k);
            if (rk) rel_valid = 1'b0;
            e_press = lvl & ~pv;
            e_rel   = ~lvl & pv & ~rk;
            e_rpt   = lvl && pv && (k - p >= D) && (((k - p - D) % P) == 0);
            e_dbl   = DBL_ON && e_press && rel_valid && (k - 1 - last_rel < W);
            if (e_press) p = k;
            if (e_rel) begin
                last_rel  = k;
                rel_valid = 1'b1;
            end

            chk("press",   k, bif.press,     e_press);
            chk("release", k, bif.release_p, e_rel);
            chk("repeat",  k, bif.repeat_p,  e_rpt);
            chk("held",    k, bif.held,      lvl);
            chk("dbl",     k, bif.dbl,       e_dbl);

            for (int j = 0; j < NL; j++) begin
                if (lit_c[j] == k) begin
                    case (lit_s[j])
                        0:       act = bif.press;
                        1:       act = bif.release_p;
                        2:       act = bif.repeat_p;
                        3:       act = bif.held;
                        default: act = bif.dbl;
                    endcase
                    chk("literal", k, act, lit_v[j]);
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
